// File: rtl/ex_wb_retire.sv
// ex_wb_retire: MEM (M) and WRITEBACK (W) pipeline registers that follow execute.
// Drives the data-memory request from M and the register-file write port from W.
// Returns forwarded rs1/rs2 operands and a load-use stall to the execute stage.
module ex_wb_retire #(
  parameter logic [5:0] LOAD_OPCODE = 6'b100011,
  parameter int         XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [5:0]      opcode_d1,
  input  logic [4:0]      rd_d1,
  input  logic [4:0]      rs1_d1,
  input  logic [4:0]      rs2_d1,
  input  logic [XLEN-1:0] reg_rs1_d1,
  input  logic [XLEN-1:0] reg_rs2_d1,
  input  logic            register_we_d1,
  input  logic            data_we_d1,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] fwd_rs1,
  output logic [XLEN-1:0] fwd_rs2,
  output logic            stall,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            reg_wr_en,
  output logic [4:0]      reg_wr_addr,
  output logic [XLEN-1:0] reg_wr_data
);

  // M keeps everything the memory request and writeback need.
  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
    logic [5:0]      op;
    logic [4:0]      rd;
    logic            rwe;
    logic            dwe;
  } m_stage_t;

  // W only needs what selects and addresses the register-file write.
  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [5:0]      op;
    logic [4:0]      rd;
    logic            rwe;
  } w_stage_t;

  m_stage_t        r_m;
  w_stage_t        r_w;
  m_stage_t        w_m_next;
  logic            w_m_is_load;
  logic            w_stall;
  logic [XLEN-1:0] w_w_result;

  // Pick the youngest in-flight producer of rs; r0 and non-writers never forward.
  // A load sitting in M is skipped: its data is not back yet and the stall covers it.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_val,
    input m_stage_t        m,
    input w_stage_t        w,
    input logic [XLEN-1:0] w_res
  );
    logic [XLEN-1:0] v;
    v = rf_val;
    if (rs != 5'd0) begin
      if (m.rwe && (m.rd == rs) && (m.op != LOAD_OPCODE)) v = m.alu;
      else if (w.rwe && (w.rd == rs))                     v = w_res;
    end
    return v;
  endfunction

  // Load-use interlock and the value W hands to the register file.
  always_comb begin
    w_m_is_load = (r_m.op == LOAD_OPCODE);
    w_stall     = r_m.rwe && w_m_is_load && (r_m.rd != 5'd0) &&
                  ((r_m.rd == rs1_d1) || (r_m.rd == rs2_d1));
    w_w_result  = (r_w.op == LOAD_OPCODE) ? mem_rdata : r_w.alu;
  end

  // Next M contents: the execute result, or an all-zero bubble while stalled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_m_next = '{alu: alu_result, sdata: store_data, op: opcode_d1,
                 rd: rd_d1, rwe: register_we_d1, dwe: data_we_d1};
    if (w_stall) w_m_next = '0;
  end

  // Advance M and W; reset discards everything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so M->W reads the old M.
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_m     <= w_m_next;
      r_w.alu <= r_m.alu;
      r_w.op  <= r_m.op;
      r_w.rd  <= r_m.rd;
      r_w.rwe <= r_m.rwe;
    end
  end

  // Output drive: memory request from M, register write and forwards from W/M.
  always_comb begin
    stall       = w_stall;
    mem_addr    = r_m.alu;
    mem_wdata   = r_m.sdata;
    mem_we      = r_m.dwe;
    reg_wr_en   = r_w.rwe && (r_w.rd != 5'd0);
    reg_wr_addr = r_w.rd;
    reg_wr_data = w_w_result;
    fwd_rs1     = fwd_sel(rs1_d1, reg_rs1_d1, r_m, r_w, w_w_result);
    fwd_rs2     = fwd_sel(rs2_d1, reg_rs2_d1, r_m, r_w, w_w_result);
  end

endmodule

// File: tb/tb_ex_wb_retire.sv
// Bench for ex_wb_retire: directed vector table, a mid-cycle reset sequence,
// then randomized traffic against an in-flight-instruction reference model.
module tb_ex_wb_retire;

  localparam logic [5:0]  LD = 6'b100011;
  localparam logic [5:0]  OP_ALU = 6'h20;
  localparam logic [5:0]  OP_ST  = 6'h2B;
  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;

  logic        clock, reset_n;
  logic [31:0] alu_result, store_data, reg_rs1_d1, reg_rs2_d1, mem_rdata;
  logic [5:0]  opcode_d1;
  logic [4:0]  rd_d1, rs1_d1, rs2_d1;
  logic        register_we_d1, data_we_d1;
  logic [31:0] fwd_rs1, fwd_rs2, mem_addr, mem_wdata, reg_wr_data;
  logic        stall, mem_we, reg_wr_en;
  logic [4:0]  reg_wr_addr;

  int n_vec  = 0;
  int n_miss = 0;

  ex_wb_retire dut (
    .clock(clock), .reset_n(reset_n), .alu_result(alu_result), .store_data(store_data),
    .opcode_d1(opcode_d1), .rd_d1(rd_d1), .rs1_d1(rs1_d1), .rs2_d1(rs2_d1),
    .reg_rs1_d1(reg_rs1_d1), .reg_rs2_d1(reg_rs2_d1), .register_we_d1(register_we_d1),
    .data_we_d1(data_we_d1), .mem_rdata(mem_rdata), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of directed stimulus with the outputs expected during that clock.
  // skip[0]: forwards don't-care, skip[1]: M is a bubble, skip[2]: W is a bubble.
  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        rwe, dwe;
    logic [31:0] alu, sd, mrd;
    logic [31:0] e_f1, e_f2;
    logic        e_st;
    logic [31:0] e_ma, e_md;
    logic        e_mwe, e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  skip;
  } vec_t;

  function automatic vec_t vec(
    input logic rst, input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
    input logic rwe, dwe, input logic [31:0] alu, sd, mrd, e_f1, e_f2,
    input logic e_st, input logic [31:0] e_ma, e_md, input logic e_mwe, e_wen,
    input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [2:0] skip);
    vec_t v;
    v.rst = rst; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.rwe = rwe; v.dwe = dwe;
    v.alu = alu; v.sd = sd; v.mrd = mrd; v.e_f1 = e_f1; v.e_f2 = e_f2; v.e_st = e_st;
    v.e_ma = e_ma; v.e_md = e_md; v.e_mwe = e_mwe; v.e_wen = e_wen; v.e_wa = e_wa;
    v.e_wd = e_wd; v.skip = skip;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic rwe, dwe, input logic [31:0] alu, sd, r1, r2, mrd);
    reset_n = rst; opcode_d1 = op; rd_d1 = rd; rs1_d1 = rs1; rs2_d1 = rs2;
    register_we_d1 = rwe; data_we_d1 = dwe; alu_result = alu; store_data = sd;
    reg_rs1_d1 = r1; reg_rs2_d1 = r2; mem_rdata = mrd;
  endtask

  // Reference model: the two youngest accepted instructions, youngest first.
  typedef struct {
    logic [31:0] alu, sd;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        rwe, dwe, bubble;
  } instr_t;

  instr_t pipe[$];

  task automatic model_clear();
    instr_t z;
    z = '{alu: 0, sd: 0, op: 0, rd: 0, rwe: 0, dwe: 0, bubble: 0};
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
  endtask

  // Value the youngest in-flight writer of rs will produce; dc when it is a load still in M.
  task automatic model_fwd(input logic [4:0] rs, input logic [31:0] rf,
                           output logic [31:0] val, output logic dc);
    logic found;
    val = rf; dc = 1'b0; found = 1'b0;
    for (int age = 0; age < 2; age++) begin
      if (!found && pipe[age].rwe && pipe[age].rd == rs && rs != 5'd0) begin
        found = 1'b1;
        if (pipe[age].op == LD) begin
          if (age == 0) dc = 1'b1;
          else          val = mem_rdata;
        end else begin
          val = pipe[age].alu;
        end
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] e1, e2;
    logic        dc1, dc2, e_st, held, prev_st;
    instr_t      ni;

    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, R1, R2, 32'd0);

    // ---------------- directed vector table ----------------
    tbl.push_back(vec(0, LD,     5, 5, 5, 1, 1, 32'hFFFF, 32'hEEEE, 32'h1234, R1, R2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, OP_ALU, 3, 3, 0, 1, 1, 32'hABCD, 32'h1, 32'h9, R1, R2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ALU, 5, 0, 0, 1, 0, 32'h10, 0, 0, R1, R2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, 6'd0,   0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 32'h10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ALU, 3, 0, 0, 1, 0, 32'hAAAA_0000, 0, 0, R1, R2, 0, 0, 0, 0, 1, 5, 32'h10, 0));
    tbl.push_back(vec(1, OP_ALU, 0, 3, 0, 0, 0, 32'h33, 0, 0, 32'hAAAA_0000, R2, 0, 32'hAAAA_0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ALU, 0, 0, 3, 0, 0, 0, 0, 0, R1, 32'hAAAA_0000, 0, 32'h33, 0, 0, 1, 3, 32'hAAAA_0000, 0));
    tbl.push_back(vec(1, OP_ALU, 7, 0, 0, 1, 0, 1, 0, 0, R1, R2, 0, 0, 0, 0, 0, 0, 32'h33, 0));
    tbl.push_back(vec(1, OP_ALU, 7, 0, 0, 1, 0, 2, 0, 0, R1, R2, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ALU, 0, 7, 0, 0, 0, 0, 0, 0, 2, R2, 0, 2, 0, 0, 1, 7, 1, 0));
    tbl.push_back(vec(1, LD,     9, 0, 0, 1, 0, 32'h40, 0, 0, R1, R2, 0, 0, 0, 0, 1, 7, 2, 0));
    tbl.push_back(vec(1, OP_ALU, 0, 0, 9, 0, 0, 32'h77, 0, 32'h5555, 0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 3'b001));
    tbl.push_back(vec(1, OP_ALU, 0, 0, 9, 0, 0, 32'h77, 0, 32'hDEAD_BEEF, R1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 9, 32'hDEAD_BEEF, 3'b010));
    tbl.push_back(vec(1, OP_ALU, 0, 0, 0, 1, 0, 32'h99, 0, 0, R1, R2, 0, 32'h77, 0, 0, 0, 0, 0, 3'b100));
    tbl.push_back(vec(1, LD,     0, 0, 0, 1, 0, 32'h50, 0, 0, R1, R2, 0, 32'h99, 0, 0, 0, 0, 32'h77, 0));
    tbl.push_back(vec(1, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 32'h50, 0, 0, 0, 0, 32'h99, 0));
    tbl.push_back(vec(1, OP_ST,  0, 0, 0, 0, 1, 32'h100, 32'h55, 0, R1, R2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, 6'd0,   0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 32'h100, 32'h55, 1, 0, 0, 0, 0));
    tbl.push_back(vec(1, 6'd0,   0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0, 0, 0, 0, 32'h100, 0));

    foreach (tbl[i]) begin
      @(negedge clock);
      drive(tbl[i].rst, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].rwe, tbl[i].dwe,
            tbl[i].alu, tbl[i].sd, R1, R2, tbl[i].mrd);
      #1;
      check($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].e_st});
      check($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].e_mwe});
      check($sformatf("v%0d reg_wr_en", i), {31'd0, reg_wr_en}, {31'd0, tbl[i].e_wen});
      check($sformatf("v%0d reg_wr_addr", i), {27'd0, reg_wr_addr}, {27'd0, tbl[i].e_wa});
      if (!tbl[i].skip[0]) begin
        check($sformatf("v%0d fwd_rs1", i), fwd_rs1, tbl[i].e_f1);
        check($sformatf("v%0d fwd_rs2", i), fwd_rs2, tbl[i].e_f2);
      end
      if (!tbl[i].skip[1]) begin
        check($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_ma);
        check($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_md);
      end
      if (!tbl[i].skip[2]) check($sformatf("v%0d reg_wr_data", i), reg_wr_data, tbl[i].e_wd);
    end

    // ---------------- reset asserted mid-cycle with a store/write in flight ----------------
    @(negedge clock);
    drive(1'b1, OP_ALU, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 32'h200, 32'h66, R1, R2, 32'd0);
    @(posedge clock);
    #1;
    check("pre-reset mem_we", {31'd0, mem_we}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset mem_we", {31'd0, mem_we}, 32'd0);
    check("async reset mem_addr", mem_addr, 32'd0);
    check("async reset reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
    repeat (2) begin
      @(negedge clock);
      check("held reset reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
      check("held reset mem_we", {31'd0, mem_we}, 32'd0);
      check("held reset reg_wr_data", reg_wr_data, 32'd0);
    end

    // ---------------- randomized traffic vs reference model ----------------
    model_clear();
    held = 1'b0;
    prev_st = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!held) begin
        opcode_d1      = ($urandom_range(0, 2) == 0) ? LD : 6'($urandom);
        rd_d1          = 5'($urandom_range(0, 7));
        rs1_d1         = 5'($urandom_range(0, 7));
        rs2_d1         = 5'($urandom_range(0, 7));
        register_we_d1 = ($urandom_range(0, 3) != 0);
        data_we_d1     = ($urandom_range(0, 3) == 0);
        alu_result     = $urandom;
        store_data     = $urandom;
        reg_rs1_d1     = $urandom;
        reg_rs2_d1     = $urandom;
      end
      mem_rdata = $urandom;
      reset_n   = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      if (!reset_n) model_clear();
      #1;

      e_st = pipe[0].rwe && pipe[0].op == LD && pipe[0].rd != 5'd0 &&
             (pipe[0].rd == rs1_d1 || pipe[0].rd == rs2_d1);
      model_fwd(rs1_d1, reg_rs1_d1, e1, dc1);
      model_fwd(rs2_d1, reg_rs2_d1, e2, dc2);

      check("rnd stall", {31'd0, stall}, {31'd0, e_st});
      if (prev_st && e_st) check("rnd stall twice", 32'd1, 32'd0);
      if (!dc1) check("rnd fwd_rs1", fwd_rs1, e1);
      if (!dc2) check("rnd fwd_rs2", fwd_rs2, e2);
      check("rnd mem_we", {31'd0, mem_we}, {31'd0, pipe[0].dwe});
      if (!pipe[0].bubble) begin
        check("rnd mem_addr", mem_addr, pipe[0].alu);
        check("rnd mem_wdata", mem_wdata, pipe[0].sd);
      end
      check("rnd reg_wr_en", {31'd0, reg_wr_en}, {31'd0, pipe[1].rwe && pipe[1].rd != 5'd0});
      check("rnd reg_wr_addr", {27'd0, reg_wr_addr}, {27'd0, pipe[1].rd});
      if (!pipe[1].bubble)
        check("rnd reg_wr_data", reg_wr_data, (pipe[1].op == LD) ? mem_rdata : pipe[1].alu);

      // Advance the model to match the coming rising edge.
      if (reset_n) begin
        if (e_st) ni = '{alu: 0, sd: 0, op: 0, rd: 0, rwe: 0, dwe: 0, bubble: 1};
        else      ni = '{alu: alu_result, sd: store_data, op: opcode_d1, rd: rd_d1,
                         rwe: register_we_d1, dwe: data_we_d1, bubble: 0};
        pipe.push_front(ni);
        void'(pipe.pop_back());
      end
      held    = reset_n && e_st;
      prev_st = reset_n && e_st;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ex_wb_retire.md
# ex_wb_retire

Retire-side counterpart to the decode-to-execute pipeline register. It accepts the execute-stage result stream (destination, write enables, opcode, ALU result, store data) and carries it through two registered stages, MEM (M) and WRITEBACK (W). It drives the register-file write port and the data-memory request. It also returns forwarded operands and a load-use stall to the execute stage, closing the loop on the delayed source registers (rs1/rs2 and their read values) that execute receives.

## Interface
- LOAD_OPCODE, 6'b100011, opcode whose result comes from data memory
- XLEN, 32, datapath width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- alu_result  in  XLEN  execute-stage result / memory address
- store_data  in  XLEN  execute-stage store operand
- opcode_d1  in  6  execute-stage opcode
- rd_d1, rs1_d1, rs2_d1  in  5  execute-stage destination / sources
- reg_rs1_d1, reg_rs2_d1  in  XLEN  register-file values read for rs1_d1/rs2_d1
- register_we_d1, data_we_d1  in  1  execute-stage write enables
- mem_rdata  in  XLEN  data-memory read data, valid the cycle after address issue
- fwd_rs1, fwd_rs2  out  XLEN  forwarded operands to execute (combinational)
- stall  out  1  load-use interlock; upstream holds execute inputs while high
- mem_addr, mem_wdata  out  XLEN  M-stage address / store data
- mem_we  out  1  M-stage data write enable
- reg_wr_en  out  1  register-file write enable (W stage)
- reg_wr_addr  out  5  register-file write address
- reg_wr_data  out  XLEN  register-file write data

## Operation
- M register captures {alu_result, store_data, opcode_d1, rd_d1, register_we_d1, data_we_d1} each clock. W register captures M each clock.
- stall = M.register_we & (M.opcode == LOAD_OPCODE) & (M.rd != 0) & (M.rd == rs1_d1 | M.rd == rs2_d1).
- While stall=1, the next M capture is a bubble: register_we=0, data_we=0, rd=0, opcode=0. W still advances from M.
- Outputs mem_addr=M.alu_result, mem_wdata=M.store_data, mem_we=M.data_we.
- Result of W: mem_rdata if W.opcode==LOAD_OPCODE, else W.alu_result.
- reg_wr_en = W.register_we & (W.rd != 0); reg_wr_addr=W.rd; reg_wr_data = result of W. Writes to r0 are suppressed.
- Forwarding for fwd_rs1 (fwd_rs2 identical with rs2):
  - Priority 1, from M: M.register_we, M.rd==rs1_d1, rs1_d1!=0, M not a load. Selects M.alu_result.
  - Priority 2, from W: W.register_we, W.rd==rs1_d1, rs1_d1!=0. Selects the result of W.
  - Otherwise reg_rs1_d1.
  - rs1_d1==0 always yields reg_rs1_d1.
- Load in M matching a source: forwarded value is don't-care, stall is high. The next cycle the load is in W and the W path forwards mem_rdata.

## Timing
- Reset (async assert, sync-safe deassert): all M/W fields = 0. Therefore reg_wr_en=0, mem_we=0, stall=0, mem_addr=mem_wdata=reg_wr_data=0, reg_wr_addr=0.
- Reset mid-operation: in-flight M/W contents are discarded, and no register or memory write occurs while reset_n=0.
- Latency: an execute-cycle result appears at mem_* 1 cycle later and at reg_wr_* 2 cycles later.
- Load-use penalty: exactly 1 cycle. stall never stays high 2 consecutive cycles for the same load, because the bubble removes the load from M.
- Simultaneous M and W match on the same rd: M wins (younger).
- Register-file read-during-write is resolved here by the W forward path. No same-cycle register-file bypass is assumed.

## Test plan
- Reset: hold reset_n=0 with random inputs -> all outputs 0. Release, then drive add rd=5, result 0x0000_0010 -> reg_wr_en=1, addr 5, data 0x10 two cycles later.
- Back-to-back ALU dependency: r3<=0xAAAA_0000, next instr rs1=3 -> fwd_rs1=0xAAAA_0000 (M path). The instr after that with rs2=3 -> fwd_rs2=0xAAAA_0000 (W path).
- Priority: r7<=1 then r7<=2, third instr rs1=7 -> fwd_rs1=2.
- Load-use: load rd=9, mem_rdata=0xDEAD_BEEF, next instr rs2=9 -> stall=1 for one cycle with a bubble in M. The following cycle stall=0, fwd_rs2=0xDEAD_BEEF, and reg_wr_data=0xDEAD_BEEF to r9.
- r0 handling: write rd=0 with register_we=1 -> reg_wr_en=0, no forwarding to rs1=0, and a load to r0 followed by rs1=0 gives stall=0.
- Store: data_we_d1=1, alu_result=0x100, store_data=0x55 -> next cycle mem_we=1, mem_addr=0x100, mem_wdata=0x55. reg_wr_en stays 0 if register_we_d1=0.
